// File: rtl/fault_pkg.sv
// Shared constants and types for the fault trigger serializer and its arbiter.
package fault_pkg;

  localparam int DEF_SOURCE_COUNT = 4;
  localparam int DEF_DEPTH        = 7;

  typedef logic [$clog2(DEF_SOURCE_COUNT)-1:0] src_idx_t;
  typedef logic [$clog2(DEF_DEPTH+1)-1:0]      pend_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_HELD  = 2'd2
  } serve_state_e;

  // Round-robin successor of a source index.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fault_trigger_serializer_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above i_ptr, modulo N.
module rr_arbiter
  import fault_pkg::*;
#(
  parameter int N = DEF_SOURCE_COUNT,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_en,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W:0]   w_wrap;
  logic             w_hit;

  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Lowest set bit of the rotated request vector is the winner's offset from i_ptr.
  always_comb begin
    w_off = '0;
    w_hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_hit = 1'b1;
        w_off = IDX_W'(k);
      end else begin
        w_hit = w_hit;
      end
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W+1)'(N)) begin
      w_wrap = w_sum - (IDX_W+1)'(N);
    end else begin
      w_wrap = w_sum;
    end
    o_grant_valid = i_en & w_hit;
    o_grant_idx   = w_wrap[IDX_W-1:0];
  end

endmodule

// File: rtl/fault_trigger_serializer.sv
// Queues per-source trigger pulses and replays them one per cycle in round-robin
// order, so simultaneous triggers reach the fault gate as separate pulses.
module fault_trigger_serializer
  import fault_pkg::*;
#(
  parameter int SOURCE_COUNT = DEF_SOURCE_COUNT,
  parameter int DEPTH        = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int SRC_W = $clog2(SOURCE_COUNT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    logic_reset,
  input  logic [SOURCE_COUNT-1:0] trig_in,
  input  logic                    stall,
  output logic                    fault_out,
  output logic [SRC_W-1:0]        fault_src,
  output logic                    pending_any,
  output logic                    overflow
);

  logic [CNT_W-1:0]        r_cnt     [SOURCE_COUNT];
  logic [CNT_W-1:0]        w_cnt_nxt [SOURCE_COUNT];
  logic [SOURCE_COUNT-1:0] w_req;
  logic [SOURCE_COUNT-1:0] w_gnt_vec;
  logic [SOURCE_COUNT-1:0] w_full;
  logic [SOURCE_COUNT-1:0] w_inc;
  logic [SOURCE_COUNT-1:0] w_drop;
  logic [SRC_W-1:0]        r_ptr;
  logic [SRC_W-1:0]        w_ptr_nxt;
  logic [SRC_W-1:0]        w_gnt_idx;
  logic                    w_gnt_valid;
  logic                    w_arb_en;
  logic                    w_pending_nxt;
  logic                    r_fault_out;
  logic [SRC_W-1:0]        r_fault_src;
  logic                    r_pending_any;
  logic                    r_overflow;

  assign w_arb_en = ~stall;

  rr_arbiter #(.N(SOURCE_COUNT)) u_rr_arbiter (
    .i_req         (w_req),
    .i_ptr         (r_ptr),
    .i_en          (w_arb_en),
    .o_grant_valid (w_gnt_valid),
    .o_grant_idx   (w_gnt_idx)
  );

  // Request vector from the registered counts.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < SOURCE_COUNT; i++) begin
      w_req[i] = (r_cnt[i] != '0);
    end
  end

  // A trigger on a full source is still accepted when that source is granted
  // at the same edge, since the grant frees a slot.
  always_comb begin
    w_gnt_vec = '0;
    w_full    = '0;
    w_inc     = '0;
    w_drop    = '0;
    w_cnt_nxt = '{default: '0};
    for (int i = 0; i < SOURCE_COUNT; i++) begin
      w_gnt_vec[i] = w_gnt_valid && (w_gnt_idx == SRC_W'(i));
      w_full[i]    = (r_cnt[i] == CNT_W'(DEPTH));
      w_inc[i]     = trig_in[i] && (!w_full[i] || w_gnt_vec[i]);
      w_drop[i]    = trig_in[i] && w_full[i] && !w_gnt_vec[i];
      case ({w_inc[i], w_gnt_vec[i]})
        2'b10:   w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        2'b01:   w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
        default: w_cnt_nxt[i] = r_cnt[i];
      endcase
    end
  end

  // Pending flag and pointer successor for the next state.
  always_comb begin
    w_pending_nxt = 1'b0;
    for (int i = 0; i < SOURCE_COUNT; i++) begin
      w_pending_nxt = w_pending_nxt | (w_cnt_nxt[i] != '0);
    end
    if (w_gnt_valid) begin
      w_ptr_nxt = SRC_W'(wrap_inc(int'(w_gnt_idx), SOURCE_COUNT));
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  // State and output registers; logic_reset keeps the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '{default: '0};
      r_ptr         <= '0;
      r_fault_out   <= 1'b0;
      r_fault_src   <= '0;
      r_pending_any <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (logic_reset) begin
      r_cnt         <= '{default: '0};
      r_ptr         <= '0;
      r_fault_out   <= 1'b0;
      r_fault_src   <= r_fault_src;
      r_pending_any <= 1'b0;
      r_overflow    <= r_overflow;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_ptr         <= w_ptr_nxt;
      r_fault_out   <= w_gnt_valid;
      r_fault_src   <= w_gnt_valid ? w_gnt_idx : r_fault_src;
      r_pending_any <= w_pending_nxt;
      r_overflow    <= r_overflow | (|w_drop);
    end
  end

  assign fault_out   = r_fault_out;
  assign fault_src   = r_fault_src;
  assign pending_any = r_pending_any;
  assign overflow    = r_overflow;

endmodule

// File: doc/fault_trigger_serializer.md
Name: fault_trigger_serializer

Overview:
- Upstream feeder for the multi-input fault gate's `fault_in` pin.
- Collects single-cycle trigger pulses from up to SOURCE_COUNT wire sources.
- Queues them as per-source pending counts.
- Replays them to the fault gate as one registered pulse per cycle, in round-robin order, so that simultaneous triggers are each evaluated separately rather than merged.

Parameters:
- SOURCE_COUNT, 4: number of trigger sources (≥2).
- DEPTH, 7: maximum pending triggers held per source (≥1).
- CNT_W, $clog2(DEPTH+1): width of each pending counter (derived; do not override).
- SRC_W, $clog2(SOURCE_COUNT): width of the source index (derived).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous active-high reset.
- logic_reset  in  1  synchronous clear of queued work (same role as on the fault gate).
- trig_in  in  SOURCE_COUNT  one bit per source; each cycle high = one trigger event.
- stall  in  1  downstream not ready; no grant is issued while high.
- fault_out  out  1  registered single-cycle trigger pulse to the fault gate.
- fault_src  out  SRC_W  index of the source served by the current fault_out pulse.
- pending_any  out  1  registered; high while any counter is nonzero.
- overflow  out  1  sticky flag: at least one trigger was dropped.

Behaviour:
- Reset (async) values:
  - all counters 0; rr pointer 0
  - fault_out 0, fault_src 0, pending_any 0, overflow 0
- Per-source counter update at each edge:
  - increment if trig_in[i]=1 and count<DEPTH.
  - decrement if source i is granted this edge.
  - both events at once: count unchanged, no overflow.
  - trig_in[i]=1 with count==DEPTH and no grant to i: trigger dropped, overflow←1.
  - counters never wrap below 0 or above DEPTH.
- Grant rule, evaluated on registered counts before the edge:
  - if stall=0 and any count nonzero: grant the first nonzero source scanning from pointer upward, modulo SOURCE_COUNT.
  - then pointer←grant+1, wrapping from SOURCE_COUNT-1 to 0.
  - if stall=1 or nothing is pending: no grant, pointer holds.
- Outputs:
  - fault_out←1 and fault_src←grant index at the granting edge; otherwise fault_out←0.
  - fault_src holds its last value while fault_out=0.
  - pending_any←OR of next-state counts.
- Latency:
  - a trigger sampled at edge k produces fault_out high in the cycle after edge k+1 (2-edge latency) when unstalled and first in rr order.
- Throughput:
  - at most 1 pulse per cycle; back-to-back pulses allowed.
- Stall:
  - stall high at edge k means fault_out=0 after edge k.
  - triggers still accumulate during stall.
  - stall carries no combinational path to any output.
- logic_reset (sync, has priority over all other updates at the edge):
  - counters←0, fault_out←0, pending_any←0, pointer←0.
  - triggers at that edge are discarded.
  - overflow is NOT cleared; only reset clears it.
- Reset asserted mid-stream:
  - all outputs drop immediately, with no partial pulse.
  - after deassertion, the first grant cannot occur before the second edge.
- No FSM beyond the counters and pointer; derived status states:
  - IDLE: no pending.
  - SERVE: pending and not stall.
  - HELD: pending and stall.

Decomposition:
- Shared package `fault_pkg`:
  - default SOURCE_COUNT/DEPTH constants.
  - typedef for source index and pending count.
- One sub-module, `rr_arbiter`:
  - parameter N.
  - inputs: request vector, pointer, enable.
  - outputs: grant_valid, grant index.
  - purely combinational.
  - the serializer owns the pointer register and the counters.

Test Plan:
- Single trigger: trig_in=4'b0100 for one cycle at edge 3, stall=0 -> fault_out=1, fault_src=2 for exactly one cycle after edge 4; pending_any 1 after edge 3, 0 after edge 4.
- Simultaneous triggers: trig_in=4'b1011 once, pointer 0 -> pulses after edges k+1, k+2, k+3 with fault_src 0, 1, 3; pointer ends at 0.
- Fairness: source 0 triggered every cycle and source 2 triggered once -> grants alternate 0, 2, 0, 0…; source 2 is served within 2 grants.
- Saturation: DEPTH=7; source 1 gets 9 triggers under stall=1 -> count 7, overflow=1; release stall -> exactly 7 pulses with fault_src=1; overflow stays 1.
- Same-edge inc/dec: source 3 count=1, trig_in[3]=1 at its grant edge -> count remains 1, second pulse next cycle, overflow=0.
- Resets: logic_reset with 5 pending -> no pulses afterwards, pending_any=0, overflow retained; async reset mid-pulse -> fault_out 0 immediately, overflow 0.
